// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - round-robin arbiter sharing one SPI flash bus between NREQ masters
//
// Ports:
//   clk, rstn                 system clock, asynchronous active-low reset
//   req[NREQ]                 per-requester bus request (level)
//   gnt[NREQ]                 registered one-hot grant
//   r_ss/r_sck/r_mosi[NREQ]   per-requester SPI pins toward the flash
//   r_miso[NREQ]              per-requester MISO view (1 when not granted)
//   spi_ss/spi_sck/spi_mosi   flash bus pins, idle ss=1 sck=0 mosi=0
//   spi_miso                  flash data out
//   busy                      high while a grant is active
//   timeout                   one-cycle pulse when the watchdog revokes a grant
module spi_flash_arbiter #(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 4,
    parameter int HOLD_MAX   = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic [NREQ-1:0] r_ss,
    input  logic [NREQ-1:0] r_sck,
    input  logic [NREQ-1:0] r_mosi,
    output logic [NREQ-1:0] r_miso,
    output logic            spi_ss,
    output logic            spi_sck,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic            busy,
    output logic            timeout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            wd_hit;
    logic            owner_req;

    function automatic logic [IW-1:0] wrap_idx(input int i);
        if (i >= NREQ) begin
            return IW'(i - NREQ);
        end
        return IW'(i);
    endfunction

    // Search downward so that the last hit written is the first set bit
    // found walking upward from the round-robin pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(rr_q) + k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(int'(rr_q) + k);
            end
        end
    end

    // hold_q counts completed grant cycles; the current cycle is the HOLD_MAX-th.
    assign wd_hit    = (HOLD_MAX > 0) && ((int'(hold_q) + 1) >= HOLD_MAX);
    assign owner_req = req[owner_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            gap_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gap_q     <= gap_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gap_d     = gap_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (HOLD_MAX > 0) begin
                    hold_d = hold_q + HW'(1);
                end
                // A watchdog revoke and a voluntary release share one path;
                // only the former raises timeout.
                if (wd_hit || !owner_req) begin
                    state_d   = S_GAP;
                    gnt_d     = '0;
                    rr_d      = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                    gap_d     = GW'(GAP_CYCLES - 1);
                    timeout_d = wd_hit;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Pins follow the owner only in GRANT, so any release or reset drops
    // the bus to idle without waiting for the requester.
    always_comb begin
        busy     = (state_q == S_GRANT);
        gnt      = gnt_q;
        timeout  = timeout_q;
        spi_ss   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        r_miso   = '1;
        if (state_q == S_GRANT) begin
            spi_ss          = r_ss[owner_q];
            spi_sck         = r_sck[owner_q];
            spi_mosi        = r_mosi[owner_q];
            r_miso[owner_q] = spi_miso;
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 4;
    localparam int HOLD = 100;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [NREQ-1:0] req    = '0;
    logic [NREQ-1:0] r_ss   = '1;
    logic [NREQ-1:0] r_sck  = '0;
    logic [NREQ-1:0] r_mosi = '0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] r_miso;
    logic            spi_ss, spi_sck, spi_mosi, busy, timeout;
    logic            use_flash  = 1'b0;
    logic            flash_miso = 1'b0;
    logic            rand_miso  = 1'b0;
    wire             spi_miso = use_flash ? flash_miso : rand_miso;

    int chk = 0;
    int err = 0;

    always #5 clk = ~clk;

    spi_flash_arbiter #(
        .NREQ(NREQ), .GAP_CYCLES(GAP), .HOLD_MAX(HOLD)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
        .r_ss(r_ss), .r_sck(r_sck), .r_mosi(r_mosi), .r_miso(r_miso),
        .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .busy(busy), .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, when they got it, when the bus was
    // last released, and whose turn is next.
    int m_owner = -1;
    int m_rr    = 0;
    int m_gedge = 0;
    int m_rel   = -1000;
    int m_edge  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner = -1;
            m_rr    = 0;
            m_rel   = -1000;
            m_edge  = 0;
            m_to    = 1'b0;
        end else begin
            bit found;
            m_edge++;
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (m_edge - m_gedge == HOLD || !req[m_owner]) begin
                    m_to    = (m_edge - m_gedge == HOLD);
                    m_rr    = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_rel   = m_edge;
                end
            end else if (m_edge - m_rel >= GAP + 1) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_rr + k) % NREQ]) begin
                        found   = 1'b1;
                        m_owner = (m_rr + k) % NREQ;
                        m_gedge = m_edge;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] em;
        logic [2:0]      ep;
        eg = '0;
        em = '1;
        ep = 3'b100;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            em[m_owner] = spi_miso;
            ep = {r_ss[m_owner], r_sck[m_owner], r_mosi[m_owner]};
        end
        check("cyc_gnt", gnt, eg);
        check("cyc_busy", busy, m_owner >= 0);
        check("cyc_timeout", timeout, m_to);
        check("cyc_pins", {spi_ss, spi_sck, spi_mosi}, ep);
        check("cyc_r_miso", r_miso, em);
    end

    // Flash stand-in: captures the command byte, then shifts out the ID on
    // falling SCK edges.
    logic [15:0] jedec_id = 16'hEF17;
    logic [7:0]  fl_cmd   = '0;
    int          fl_cnt   = 0;
    logic        fl_sck_prev = 1'b0;

    always @(spi_ss or spi_sck) begin
        if (spi_ss) begin
            fl_cnt = 0;
        end else if (spi_sck && !fl_sck_prev) begin
            if (fl_cnt < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
            fl_cnt++;
        end else if (!spi_sck && fl_sck_prev && fl_cnt >= 8 && fl_cnt < 24) begin
            flash_miso = jedec_id[23 - fl_cnt];
        end
        fl_sck_prev = spi_sck;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        req    = '0;
        r_ss   = '1;
        r_sck  = '0;
        r_mosi = '0;
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] want, input int maxc, output int n);
        n = 0;
        while (gnt !== want && n < maxc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        int          bad;
        int          tos;
        logic [15:0] id;
        logic [7:0]  cmd;
        logic [NREQ-1:0] seq [4];

        // Reset state and single-requester latency
        rstn = 1'b0;
        repeat (3) tick();
        check("rst_gnt", gnt, 0);
        check("rst_pins", {spi_ss, spi_sck, spi_mosi}, 3'b100);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rstn = 1'b1;
        repeat (7) tick();
        req[0] = 1'b1;
        check("single_pre_gnt", gnt, 2'b00);
        tick();
        check("single_gnt", gnt, 2'b01);

        // JEDEC ID read through requester 0
        use_flash = 1'b1;
        cmd = 8'h9F;
        id  = '0;
        bad = 0;
        r_ss[0] = 1'b0;
        tick();
        for (int b = 0; b < 24; b++) begin
            r_mosi[0] = (b < 8) ? cmd[7 - b] : 1'b0;
            r_sck[0]  = 1'b0;
            tick();
            if (b >= 8) id = {id[14:0], r_miso[0]};
            if (r_miso[1] !== 1'b1) bad++;
            r_sck[0] = 1'b1;
            tick();
            if (r_miso[1] !== 1'b1) bad++;
        end
        r_sck[0] = 1'b0;
        tick();
        check("jedec_cmd", fl_cmd, 8'h9F);
        check("jedec_id", id, 16'hEF17);
        check("jedec_miso1_idle", bad, 0);
        r_ss[0]  = 1'b1;
        r_mosi[0] = 1'b0;
        tick();
        req[0] = 1'b0;
        tick();
        check("single_release", gnt, 2'b00);
        use_flash = 1'b0;

        // Contention and gap timing
        do_reset();
        req = 2'b11;
        tick();
        check("cont_first", gnt, 2'b01);
        r_ss[1] = 1'b0;
        repeat (8) tick();
        req[0] = 1'b0;
        tick();
        check("cont_release", gnt, 2'b00);
        n   = 0;
        bad = 0;
        while (gnt !== 2'b10 && n < 20) begin
            if (spi_ss !== 1'b1) bad++;
            tick();
            n++;
        end
        check("cont_gap_len", n, GAP + 1);
        check("cont_gap_ss", bad, 0);
        check("cont_second", gnt, 2'b10);
        r_ss[1] = 1'b1;
        req[1]  = 1'b0;
        tick();

        // Fairness with both requesters always re-requesting
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (gnt === '0 && n < 20) begin
                tick();
                n++;
            end
            seq[i] = gnt;
            repeat (19) tick();
            req = req & ~gnt;
            tick();
            req = 2'b11;
        end
        check("fair_0", seq[0], 2'b01);
        check("fair_1", seq[1], 2'b10);
        check("fair_2", seq[2], 2'b01);
        check("fair_3", seq[3], 2'b10);
        req = '0;
        repeat (8) tick();

        // Watchdog revokes a stuck requester
        do_reset();
        req     = 2'b10;
        r_ss[1] = 1'b0;
        tick();
        check("wd_gnt1", gnt, 2'b10);
        req[0] = 1'b1;
        n   = 0;
        tos = 0;
        while (gnt === 2'b10 && n < 300) begin
            if (timeout !== 1'b0) tos++;
            n++;
            tick();
        end
        check("wd_hold_len", n, HOLD);
        check("wd_early_timeout", tos, 0);
        check("wd_pulse", timeout, 1);
        check("wd_ss_idle", spi_ss, 1);
        tick();
        check("wd_pulse_end", timeout, 0);
        n = 1;
        while (gnt !== 2'b01 && n < 20) begin
            tick();
            n++;
        end
        check("wd_next_gap", n, GAP + 1);
        check("wd_next_gnt", gnt, 2'b01);
        req  = '0;
        r_ss = '1;
        repeat (8) tick();

        // Asynchronous reset in the middle of a transfer
        do_reset();
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        req = 2'b10;
        wait_gnt(2'b10, 20, n);
        check("arst_pre_gnt", gnt, 2'b10);
        r_ss[1]   = 1'b0;
        r_sck[1]  = 1'b1;
        r_mosi[1] = 1'b1;
        #1;
        check("arst_pins_live", {spi_ss, spi_sck, spi_mosi}, 3'b011);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_pins_idle", {spi_ss, spi_sck, spi_mosi}, 3'b100);
        check("arst_gnt", gnt, 2'b00);
        check("arst_busy", busy, 0);
        tick();
        r_ss   = '1;
        r_sck  = '0;
        r_mosi = '0;
        req    = 2'b11;
        rstn   = 1'b1;
        tick();
        check("arst_rr_restart", gnt, 2'b01);
        req = '0;
        repeat (8) tick();

        // Idle bus
        do_reset();
        bad = 0;
        repeat (1000) begin
            if (spi_ss !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) bad++;
            tick();
        end
        check("idle_quiet", bad, 0);

        // Randomized traffic checked by the per-cycle model compare
        do_reset();
        repeat (4000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ($urandom % 60) == 0) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 8) == 0) req[i] = 1'b1;
            end
            r_ss      = NREQ'($urandom);
            r_sck     = NREQ'($urandom);
            r_mosi    = NREQ'($urandom);
            rand_miso = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
